// File: rtl/uart_parity_unit_if.sv
// Handshake bundle for uart_parity_unit: upstream word, downstream result,
// error reporting. master drives words in, slave is the parity unit.
interface uart_parity_unit_if #(
    parameter int WORD_SIZE = 8,
    parameter int CNT_WIDTH = 8
);
    logic                 i_valid;
    logic                 o_ready;
    logic [WORD_SIZE-1:0] i_word;
    logic [2:0]           i_mode;
    logic                 i_chk;
    logic                 i_rx_parity;
    logic                 o_valid;
    logic                 i_ready;
    logic [WORD_SIZE-1:0] o_word;
    logic                 o_parity;
    logic                 o_err;
    logic                 o_err_sticky;
    logic                 i_clr;
    logic [CNT_WIDTH-1:0] o_err_cnt;

    modport master (
        output i_valid, i_word, i_mode, i_chk, i_rx_parity,
        output i_ready, i_clr,
        input  o_ready, o_valid, o_word, o_parity,
        input  o_err, o_err_sticky, o_err_cnt
    );

    modport slave (
        input  i_valid, i_word, i_mode, i_chk, i_rx_parity,
        input  i_ready, i_clr,
        output o_ready, o_valid, o_word, o_parity,
        output o_err, o_err_sticky, o_err_cnt
    );
endinterface

// File: rtl/uart_parity_unit.sv
// Registered parity generator/checker; one word per handshake, latency 1.
// Define UART_PARITY_ERR_CNT_EN to build the saturating error counter.
module uart_parity_unit #(
    parameter int WORD_SIZE = 8,
    parameter int CNT_WIDTH = 8
) (
    input logic            i_clk,
    input logic            i_rst,
    uart_parity_unit_if.slave bus
);
    logic x;
    logic par;
    logic none;
    logic err;
    logic ready;
    logic accept;

    assign ready       = !bus.o_valid || bus.i_ready;
    assign accept      = bus.i_valid && ready;
    assign bus.o_ready = ready;

    always_comb begin
        x    = ^bus.i_word;
        par  = 1'b0;
        none = 1'b1;
        unique case (1'b1)
            (bus.i_mode == 3'b001): begin
                par  = x;
                none = 1'b0;
            end
            (bus.i_mode == 3'b010): begin
                par  = ~x;
                none = 1'b0;
            end
            (bus.i_mode == 3'b011): begin
                par  = 1'b1;
                none = 1'b0;
            end
            (bus.i_mode == 3'b100): begin
                par  = 1'b0;
                none = 1'b0;
            end
            default: ;
        endcase
    end

    assign err = bus.i_chk && !none && (par != bus.i_rx_parity);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_valid  <= 1'b0;
            bus.o_word   <= '0;
            bus.o_parity <= 1'b0;
            bus.o_err    <= 1'b0;
        end else if (accept) begin
            bus.o_valid  <= 1'b1;
            bus.o_word   <= bus.i_word;
            bus.o_parity <= par;
            bus.o_err    <= err;
        end else if (bus.i_ready) begin
            bus.o_valid  <= 1'b0;
        end
    end

    // A fresh error outranks a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_err_sticky <= 1'b0;
        end else if (accept && err) begin
            bus.o_err_sticky <= 1'b1;
        end else if (bus.i_clr) begin
            bus.o_err_sticky <= 1'b0;
        end
    end

`ifdef UART_PARITY_ERR_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_err_cnt <= '0;
        end else if (accept && err) begin
            if (bus.i_clr) begin
                bus.o_err_cnt <= CNT_ONE;
            end else if (bus.o_err_cnt != CNT_MAX) begin
                bus.o_err_cnt <= bus.o_err_cnt + CNT_ONE;
            end
        end else if (bus.i_clr) begin
            bus.o_err_cnt <= '0;
        end
    end
`else
    assign bus.o_err_cnt = '0;
`endif
endmodule
